// File: rtl/u_xmit_gen.sv
// UART transmitter: circular TX FIFO feeding a registered frame generator
// (start, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits).
module u_xmit_gen #(
  parameter int DATA_W     = 8,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          xmitH,
  input  logic [DATA_W-1:0]             xmit_dataH,
  output logic                          xmit_readyH,
  output logic                          uart_xmitH,
  output logic                          xmit_busyH,
  output logic                          xmit_doneH,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_countH,
  output logic                          xmit_ovfH
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(OVS);
  localparam int BW = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_q;
  logic [CW-1:0]       cell_q;
  logic [BW-1:0]       bit_q;
  logic [DATA_W-1:0]   sh_q;
  logic                par_q, line_q, done_q;

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [AW:0]         count_q;
  logic                ovf_q;

  logic                full, push, pop, cell_end, stop_last, frame_end;
  logic [DATA_W-1:0]   head;

  assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
  assign push      = xmitH && !full;
  assign cell_end  = (cell_q == CW'(OVS-1));
  assign stop_last = (bit_q == BW'(STOP_BITS-1));
  assign frame_end = (state_q == STOP) && cell_end && stop_last;
  // Pop decisions use the registered count only, so a same-cycle write
  // never reaches the line before the following edge.
  assign pop       = (count_q != '0) && ((state_q == IDLE) || frame_end);
  assign head      = mem_q[rptr_q];

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wptr_q] <= xmit_dataH;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      ovf_q <= ovf_q | (xmitH & full);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cell_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      // Raised one clock early so it is high during the frame's last clock.
      done_q <= (state_q == STOP) && stop_last && (cell_q == CW'(OVS-2));
      cell_q <= ((state_q == IDLE) || cell_end) ? '0 : cell_q + 1'b1;
      case (state_q)
        IDLE: if (pop) begin
          state_q <= START;
          line_q  <= 1'b0;
          sh_q    <= head;
          par_q   <= (^head) ^ (PARITY_ODD != 0);
        end
        START: if (cell_end) begin
          state_q <= DATA;
          line_q  <= sh_q[0];
          sh_q    <= sh_q >> 1;
          bit_q   <= '0;
        end
        DATA: if (cell_end) begin
          if (bit_q == BW'(DATA_W-1)) begin
            bit_q <= '0;
            if (PARITY_EN != 0) begin
              state_q <= PARITY;
              line_q  <= par_q;
            end else begin
              state_q <= STOP;
              line_q  <= 1'b1;
            end
          end else begin
            bit_q  <= bit_q + 1'b1;
            line_q <= sh_q[0];
            sh_q   <= sh_q >> 1;
          end
        end
        PARITY: if (cell_end) begin
          state_q <= STOP;
          line_q  <= 1'b1;
          bit_q   <= '0;
        end
        STOP: if (cell_end) begin
          if (stop_last) begin
            bit_q <= '0;
            if (pop) begin
              state_q <= START;
              line_q  <= 1'b0;
              sh_q    <= head;
              par_q   <= (^head) ^ (PARITY_ODD != 0);
            end else begin
              state_q <= IDLE;
              line_q  <= 1'b1;
            end
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          line_q  <= 1'b1;
        end
      endcase
    end
  end

  assign xmit_readyH = !full;
  assign uart_xmitH  = line_q;
  assign xmit_busyH  = (state_q != IDLE);
  assign xmit_doneH  = done_q;
  assign fifo_countH = count_q;
  assign xmit_ovfH   = ovf_q;

endmodule

// File: tb/tb_u_xmit_gen.sv
// Bench for u_xmit_gen: parity table, directed multi-cycle sequences and a
// random write stream on the default instance checked against a timeline model.
module tb_u_xmit_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       w, line, busy, done, rdy, ovf;
  logic [3:0][7:0]  d;
  logic [3:0][2:0]  cnt;

  int tests = 0;
  int fails = 0;
  int e = 0;

  u_xmit_gen dut0 (.sys_clk(clk), .sys_rst(rst), .xmitH(w[0]), .xmit_dataH(d[0]),
    .xmit_readyH(rdy[0]), .uart_xmitH(line[0]), .xmit_busyH(busy[0]),
    .xmit_doneH(done[0]), .fifo_countH(cnt[0]), .xmit_ovfH(ovf[0]));
  u_xmit_gen #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (.sys_clk(clk), .sys_rst(rst),
    .xmitH(w[1]), .xmit_dataH(d[1]), .xmit_readyH(rdy[1]), .uart_xmitH(line[1]),
    .xmit_busyH(busy[1]), .xmit_doneH(done[1]), .fifo_countH(cnt[1]), .xmit_ovfH(ovf[1]));
  u_xmit_gen #(.PARITY_EN(1), .PARITY_ODD(1)) dut2 (.sys_clk(clk), .sys_rst(rst),
    .xmitH(w[2]), .xmit_dataH(d[2]), .xmit_readyH(rdy[2]), .uart_xmitH(line[2]),
    .xmit_busyH(busy[2]), .xmit_doneH(done[2]), .fifo_countH(cnt[2]), .xmit_ovfH(ovf[2]));
  u_xmit_gen #(.DATA_W(7), .OVS(4), .STOP_BITS(2)) dut3 (.sys_clk(clk), .sys_rst(rst),
    .xmitH(w[3]), .xmit_dataH(d[3][6:0]), .xmit_readyH(rdy[3]), .uart_xmitH(line[3]),
    .xmit_busyH(busy[3]), .xmit_doneH(done[3]), .fifo_countH(cnt[3]), .xmit_ovfH(ovf[3]));

  typedef struct {
    logic [7:0] data;
    logic       par_even;
    logic       par_odd;
  } vec_t;
  vec_t tv [6];

  // dut0 model: each accepted write becomes a frame with a known start edge
  localparam int L0 = 160;
  int         ms[$];
  logic [7:0] md[$];
  int         dq[$];
  int         last_s;
  bit         movf;
  int         busy_run;

  task automatic tick();
    @(posedge clk);
    e++;
    #1;
  endtask

  task automatic chk(string nm, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic run_frame(int u, int data, int dw, int ovs, int pe, int par, int sb, string nm);
    int L, bad, dpos, nd, bc;
    logic [15:0] bits;
    L = ovs * (1 + dw + pe + sb);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < dw; i++) bits[1+i] = ((data >> i) & 1) != 0;
    if (pe != 0) bits[1+dw] = (par != 0);
    w[u] = 1'b1;
    d[u] = 8'(data);
    tick();
    w[u] = 1'b0;
    bad = 0; dpos = -1; nd = 0; bc = 0;
    for (int j = 1; j <= L + 2; j++) begin
      tick();
      if (line[u] !== ((j <= L) ? bits[(j-1)/ovs] : 1'b1)) bad++;
      if (done[u]) begin nd++; dpos = j; end
      if (busy[u]) bc++;
    end
    chk({nm, " line errors"}, bad, 0);
    chk({nm, " done clock"}, dpos, L);
    chk({nm, " done count"}, nd, 1);
    chk({nm, " busy clocks"}, bc, L);
  endtask

  task automatic model_clear();
    ms.delete();
    md.delete();
    last_s = -100000;
  endtask

  task automatic mstep(bit wr, logic [7:0] dat);
    int k, pend, b, eline, edone, ebusy, ecnt;
    k = e + 1;
    w[0] = wr;
    d[0] = dat;
    if (wr) begin
      pend = 0;
      foreach (ms[i]) if (ms[i] >= k) pend++;
      if (pend < 4) begin
        ms.push_back((k + 1 > last_s + L0) ? k + 1 : last_s + L0);
        last_s = ms[$];
        md.push_back(dat);
      end else movf = 1'b1;
    end
    tick();
    w[0] = 1'b0;
    eline = 1; edone = 0; ebusy = 0; ecnt = 0;
    foreach (ms[i]) begin
      if (ms[i] <= k && k < ms[i] + L0) begin
        ebusy = 1;
        b = (k - ms[i]) / 16;
        eline = (b == 0) ? 0 : (b <= 8) ? int'((md[i] >> (b-1)) & 8'd1) : 1;
      end
      if (ms[i] + L0 - 1 == k) edone = 1;
      if (ms[i] > k) ecnt++;
    end
    if (done[0]) dq.push_back(k);
    if (busy[0]) busy_run++;
    if (fails < 50) begin
      tests++;
      if (line[0] !== eline[0] || busy[0] !== ebusy[0] || done[0] !== edone[0] ||
          cnt[0] !== ecnt[2:0] || rdy[0] !== (ecnt != 4) || ovf[0] !== movf) begin
        fails++;
        $display("FAIL model edge %0d: line %b/%0d busy %b/%0d done %b/%0d cnt %0d/%0d rdy %b ovf %b/%0d",
                 k, line[0], eline, busy[0], ebusy, done[0], edone, cnt[0], ecnt, rdy[0], ovf[0], movf);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    tv[0] = '{8'h07, 1'b1, 1'b0};
    tv[1] = '{8'h00, 1'b0, 1'b1};
    tv[2] = '{8'hFF, 1'b0, 1'b1};
    tv[3] = '{8'h01, 1'b1, 1'b0};
    tv[4] = '{8'h80, 1'b1, 1'b0};
    tv[5] = '{8'h55, 1'b0, 1'b1};
    w = '0;
    d = '0;
    movf = 1'b0;
    busy_run = 0;
    model_clear();

    tick(); tick();
    chk("rst line", line[0], 1);
    chk("rst busy", busy[0], 0);
    chk("rst done", done[0], 0);
    chk("rst ready", rdy[0], 1);
    chk("rst count", cnt[0], 0);
    chk("rst ovf", ovf[0], 0);
    chk("rst line dut3", line[3], 1);

    // first edge after release must accept the write
    rst = 1'b0;
    run_frame(0, 8'h55, 8, 16, 0, 0, 1, "f55");

    foreach (tv[i]) begin
      run_frame(1, tv[i].data, 8, 16, 1, tv[i].par_even, 1, "par even");
      run_frame(2, tv[i].data, 8, 16, 1, tv[i].par_odd, 1, "par odd");
    end

    run_frame(3, 8'h5A, 7, 4, 0, 0, 2, "stop2");

    model_clear();
    dq.delete();
    busy_run = 0;
    mstep(1'b1, 8'h01);
    mstep(1'b1, 8'h80);
    mstep(1'b1, 8'hFF);
    repeat (500) mstep(1'b0, 8'h00);
    chk("b2b dones", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("b2b gap1", dq[1] - dq[0], 160);
      chk("b2b gap2", dq[2] - dq[1], 160);
    end
    chk("b2b busy clocks", busy_run, 480);

    dq.delete();
    for (int i = 0; i < 6; i++) mstep(1'b1, 8'(8'h10 + i));
    chk("ovf count", cnt[0], 4);
    chk("ovf flag", ovf[0], 1);
    repeat (5*160 + 20) mstep(1'b0, 8'h00);
    chk("ovf frames", dq.size(), 5);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        repeat (6) mstep(1'b1, 8'($urandom));
      end else begin
        mstep($urandom_range(0, 99) < 4, 8'($urandom));
      end
    end
    repeat (900) mstep(1'b0, 8'h00);

    w[0] = 1'b1; d[0] = 8'hA1;
    tick();
    d[0] = 8'h11;
    tick();
    w[0] = 1'b0;
    repeat (49) tick();
    chk("pre-reset line", line[0], 0);
    chk("pre-reset count", cnt[0], 1);
    rst = 1'b1;
    #1;
    chk("async reset line", line[0], 1);
    chk("async reset count", cnt[0], 0);
    chk("async reset busy", busy[0], 0);
    begin
      int nd;
      nd = 0;
      repeat (3) begin
        tick();
        if (done[0]) nd++;
      end
      chk("reset no done", nd, 0);
    end
    chk("reset ovf", ovf[0], 0);
    rst = 1'b0;
    run_frame(0, 8'h3C, 8, 16, 0, 0, 1, "post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
